// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared opcodes, shift funct3 codes and the immediate-format enum
//   OP_*      : RV32I/RV64I major opcodes that carry an immediate
//   F3_SLL/SR : funct3 values that turn OP-IMM / OP-IMM-32 into shift-immediates
//   imm_type_e: 3-bit immediate format classification
package imm_gen_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_SR     = 3'b101;
    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_SHAMT = 3'd2,
        IMM_S     = 3'd3,
        IMM_B     = 3'd4,
        IMM_J     = 3'd5,
        IMM_U     = 3'd6
    } imm_type_e;
endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational immediate extraction and format classification
//   XLEN   : 32 or 64, width of the sign-extended immediate
//   i_inst : raw 32-bit instruction
//   o_imm  : immediate, sign-extended (shift amounts zero-extended) to XLEN
//   o_type : detected immediate format, IMM_NONE for opcodes without one
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_inst,
    output logic [XLEN-1:0] o_imm,
    output imm_type_e       o_type
);
    // Every format fits in 32 bits sign-extended; widening to XLEN is one signed cast.
    logic [31:0] w_imm32;
    logic        w_shift;
    logic [31:0] w_i_imm;
    logic [31:0] w_sh5;

    assign w_shift = (i_inst[14:12] == F3_SLL) || (i_inst[14:12] == F3_SR);
    assign w_i_imm = {{20{i_inst[31]}}, i_inst[31:20]};
    // Only shamt bits are kept so the SRAI/SRAIW funct7 bit inst[30] never reaches the output.
    assign w_sh5   = {27'd0, i_inst[24:20]};

    always_comb begin
        w_imm32 = 32'd0;
        o_type  = IMM_NONE;
        case (i_inst[6:0])
            OP_LOAD, OP_JALR: begin
                w_imm32 = w_i_imm;
                o_type  = IMM_I;
            end
            OP_IMM: begin
                w_imm32 = w_shift ? {26'd0, (XLEN == 64) ? i_inst[25] : 1'b0, i_inst[24:20]} : w_i_imm;
                o_type  = w_shift ? IMM_SHAMT : IMM_I;
            end
            OP_IMM32: begin
                if (XLEN == 64) begin
                    w_imm32 = w_shift ? w_sh5 : w_i_imm;
                    o_type  = w_shift ? IMM_SHAMT : IMM_I;
                end
            end
            OP_STORE: begin
                w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
                o_type  = IMM_S;
            end
            OP_BRANCH: begin
                w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
                o_type  = IMM_B;
            end
            OP_JAL: begin
                w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
                o_type  = IMM_J;
            end
            OP_LUI, OP_AUIPC: begin
                w_imm32 = {i_inst[31:12], 12'd0};
                o_type  = IMM_U;
            end
            default: ;
        endcase
    end

    assign o_imm = XLEN'($signed(w_imm32));
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with valid/ready and a one-entry skid
//   clk, reset_n          : clock, asynchronous active-low reset
//   flush                 : synchronous kill of output and skid entries
//   in_valid/in_ready     : upstream handshake for inst_code and in_tag
//   out_valid/out_ready   : downstream handshake for Imm_out, imm_type, out_tag
//   Imm_out/imm_type      : decoded immediate and its format
//   out_tag               : opaque sideband travelling with each instruction
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst_code,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  Imm_out,
    output imm_type_e        imm_type,
    output logic [TAG_W-1:0] out_tag
);
    logic [XLEN-1:0]  w_imm;
    imm_type_e        w_type;
    logic             w_acc;
    logic             w_load;
    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_imm;
    imm_type_e        r_out_type;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_skid_valid;
    logic [XLEN-1:0]  r_skid_imm;
    imm_type_e        r_skid_type;
    logic [TAG_W-1:0] r_skid_tag;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .i_inst (inst_code),
        .o_imm  (w_imm),
        .o_type (w_type)
    );

    // in_ready comes straight from the skid flag so it never depends on out_ready combinationally.
    assign w_acc  = in_valid & ~r_skid_valid;
    // Output register may take a new entry when empty or being drained this cycle.
    assign w_load = ~r_out_valid | out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid  <= 1'b0;
            r_out_imm    <= '0;
            r_out_type   <= IMM_NONE;
            r_out_tag    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_type  <= IMM_NONE;
            r_skid_tag   <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_load) begin
            // Skid holds the older entry, so it has priority; w_acc is 0 whenever skid is occupied.
            r_out_valid  <= r_skid_valid | w_acc;
            r_skid_valid <= 1'b0;
            if (r_skid_valid) begin
                r_out_imm  <= r_skid_imm;
                r_out_type <= r_skid_type;
                r_out_tag  <= r_skid_tag;
            end else if (w_acc) begin
                r_out_imm  <= w_imm;
                r_out_type <= w_type;
                r_out_tag  <= in_tag;
            end
        end else if (w_acc) begin
            r_skid_valid <= 1'b1;
            r_skid_imm   <= w_imm;
            r_skid_type  <= w_type;
            r_skid_tag   <= in_tag;
        end
    end

    assign in_ready  = ~r_skid_valid;
    assign out_valid = r_out_valid;
    assign Imm_out   = r_out_imm;
    assign imm_type  = r_out_type;
    assign out_tag   = r_out_tag;
endmodule
